// File: rtl/secure_uart_link.sv
// Secure serial link: TX FIFO, sequence tagging and a UART-style serialiser,
// plus an RX deserialiser with a replay/gap check on the sequence tag.
module secure_uart_link #(
    parameter int DATA_W       = 8,
    parameter int SEQ_W        = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 27
) (
    input  logic              clk_3125,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              tx_busy,
    output logic              tx_line,
    input  logic              rx_line,
    output logic [DATA_W-1:0] rx_msg,
    output logic              rx_valid,
    output logic              replay_error,
    output logic              seq_gap,
    output logic              frame_error,
    output logic [7:0]        err_count
);

    localparam int FRAME_W = DATA_W + SEQ_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt, fifo_cnt_nxt;
    logic              push, pop;

    state_t            tx_state;
    logic [CNT_W-1:0]  tx_cnt;
    logic [BIT_W-1:0]  tx_bit;
    logic [FRAME_W-1:0] tx_sh;
    logic [SEQ_W-1:0]  tx_seq;

    assign push    = wr_en && !full;
    assign pop     = (tx_state == S_IDLE) && (fifo_cnt != '0);
    assign tx_busy = (tx_state != S_IDLE);

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop)
            fifo_cnt_nxt = fifo_cnt + 1'b1;
        else if (pop && !push)
            fifo_cnt_nxt = fifo_cnt - 1'b1;
    end

    always_ff @(posedge clk_3125) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_3125 or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            full     <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt_nxt;
            full     <= (fifo_cnt_nxt == DEPTH_CNT);
        end
    end

    // tx_bit counts the payload bits still to send after the one on the line
    always_ff @(posedge clk_3125 or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_seq   <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (pop) begin
                        tx_sh    <= {tx_seq, mem[rd_ptr]};
                        tx_cnt   <= BIT_LAST;
                        tx_line  <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_line  <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                        tx_cnt   <= BIT_LAST;
                        tx_bit   <= FRAME_LAST;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_bit == '0) begin
                            tx_line  <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_line <= tx_sh[0];
                            tx_sh   <= tx_sh >> 1;
                            tx_bit  <= tx_bit - 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == '0) begin
                        tx_seq   <= tx_seq + 1'b1;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    logic               rx_s1, rx_s2, rx_s3;
    state_t             rx_state;
    logic [CNT_W-1:0]   rx_cnt;
    logic [BIT_W-1:0]   rx_bit;
    logic [FRAME_W-1:0] rx_sh;
    logic [SEQ_W-1:0]   expected, rx_seq, rx_d;
    logic [DATA_W-1:0]  rx_data;

    assign rx_seq  = rx_sh[FRAME_W-1:DATA_W];
    assign rx_data = rx_sh[DATA_W-1:0];
    assign rx_d    = rx_seq - expected;

    // rx_s3 only serves falling-edge detection on the synchronised line
    always_ff @(posedge clk_3125 or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_line;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_ff @(posedge clk_3125 or posedge reset) begin
        if (reset) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            expected     <= '0;
            rx_msg       <= '0;
            rx_valid     <= 1'b0;
            replay_error <= 1'b0;
            seq_gap      <= 1'b0;
            frame_error  <= 1'b0;
            err_count    <= '0;
        end else begin
            rx_valid     <= 1'b0;
            replay_error <= 1'b0;
            seq_gap      <= 1'b0;
            frame_error  <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_cnt   <= HALF_LAST;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        if (!rx_s2) begin
                            rx_cnt   <= BIT_LAST;
                            rx_bit   <= FRAME_LAST;
                            rx_state <= S_DATA;
                        end else begin
                            rx_state <= S_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_sh  <= {rx_s2, rx_sh[FRAME_W-1:1]};
                        rx_cnt <= BIT_LAST;
                        if (rx_bit == '0)
                            rx_state <= S_STOP;
                        else
                            rx_bit <= rx_bit - 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= S_IDLE;
                        if (!rx_s2) begin
                            frame_error <= 1'b1;
                        end else if (!rx_d[SEQ_W-1]) begin
                            // forward distance under half the tag space: accept
                            rx_msg   <= rx_data;
                            rx_valid <= 1'b1;
                            seq_gap  <= (rx_d != '0);
                            expected <= rx_seq + 1'b1;
                        end else begin
                            replay_error <= 1'b1;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secure_uart_link.sv
// Directed bench for secure_uart_link: loopback transfers, injected frames
// for replay/gap/framing cases, error saturation and reset mid-frame.
module tb_secure_uart_link;

    localparam int DATA_W = 8;
    localparam int SEQ_W  = 4;
    localparam int DEPTH  = 4;
    localparam int CPB    = 4;

    logic              clk_3125 = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full, tx_busy, tx_line, rx_line;
    logic [DATA_W-1:0] rx_msg;
    logic              rx_valid, replay_error, seq_gap, frame_error;
    logic [7:0]        err_count;
    logic              loopback, inj_line;

    assign rx_line = loopback ? tx_line : inj_line;

    secure_uart_link #(
        .DATA_W(DATA_W), .SEQ_W(SEQ_W), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_3125(clk_3125), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .tx_busy(tx_busy), .tx_line(tx_line), .rx_line(rx_line),
        .rx_msg(rx_msg), .rx_valid(rx_valid), .replay_error(replay_error),
        .seq_gap(seq_gap), .frame_error(frame_error), .err_count(err_count)
    );

    always #5 clk_3125 = ~clk_3125;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid = 0, n_replay = 0, n_gap = 0, n_ferr = 0, n_bad = 0;
    int s_valid, s_replay, s_gap, s_ferr;
    logic [7:0] got_q[$];

    always @(negedge clk_3125) begin
        if (rx_valid) begin
            n_valid++;
            got_q.push_back(rx_msg);
        end
        if (replay_error) n_replay++;
        if (seq_gap) n_gap++;
        if (frame_error) n_ferr++;
        if ((int'(rx_valid) + int'(replay_error) + int'(frame_error)) > 1 || (seq_gap && !rx_valid))
            n_bad++;
    end

    typedef struct {
        logic       rst;
        logic [3:0] seq;
        logic [7:0] data;
        logic       stop;
        logic [3:0] flags;   // {valid, gap, replay, frame}
        logic [7:0] msg;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_valid  = n_valid;
        s_replay = n_replay;
        s_gap    = n_gap;
        s_ferr   = n_ferr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_3125);
        @(negedge clk_3125) reset = 1'b0;
    endtask

    task automatic write_raw(input logic [7:0] d);
        @(negedge clk_3125);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk_3125);
        #1 wr_en = 1'b0;
    endtask

    task automatic write_wait(input logic [7:0] d);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_3125);
            if (!full) break;
        end
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk_3125);
        #1 wr_en = 1'b0;
    endtask

    task automatic inject(input logic [3:0] seq, input logic [7:0] d, input logic stop);
        logic [13:0] f;
        f = {stop, seq, d, 1'b0};
        for (int i = 0; i < 14; i++) begin
            inj_line = f[i];
            repeat (CPB) @(posedge clk_3125);
        end
        inj_line = 1'b1;
        repeat (2 * CPB) @(posedge clk_3125);
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_3125);
            if (got_q.size() >= target) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [13:0] cap;

        vecs[0]  = '{1'b1, 4'd0, 8'h11, 1'b1, 4'b1000, 8'h11, 8'd0};
        vecs[1]  = '{1'b0, 4'd0, 8'h22, 1'b1, 4'b0010, 8'h11, 8'd1};
        vecs[2]  = '{1'b1, 4'd0, 8'h11, 1'b1, 4'b1000, 8'h11, 8'd0};
        vecs[3]  = '{1'b0, 4'd3, 8'h33, 1'b1, 4'b1100, 8'h33, 8'd0};
        vecs[4]  = '{1'b0, 4'd4, 8'h44, 1'b1, 4'b1000, 8'h44, 8'd0};
        vecs[5]  = '{1'b0, 4'd2, 8'h55, 1'b1, 4'b0010, 8'h44, 8'd1};
        vecs[6]  = '{1'b1, 4'd0, 8'h66, 1'b0, 4'b0001, 8'h00, 8'd0};
        vecs[7]  = '{1'b0, 4'd0, 8'h77, 1'b1, 4'b1000, 8'h77, 8'd0};
        vecs[8]  = '{1'b0, 4'd1, 8'h88, 1'b1, 4'b1000, 8'h88, 8'd0};
        vecs[9]  = '{1'b0, 4'd9, 8'h99, 1'b1, 4'b1100, 8'h99, 8'd0};
        vecs[10] = '{1'b0, 4'd2, 8'hAA, 1'b1, 4'b0010, 8'h99, 8'd1};

        reset = 1'b1; wr_en = 1'b0; wr_data = '0; loopback = 1'b1; inj_line = 1'b1;
        repeat (3) @(posedge clk_3125);
        #1;
        check("reset_outs", {tx_line, full, tx_busy, rx_valid, replay_error, seq_gap, frame_error}, 7'b1000000);
        check("reset_msg_err", {rx_msg, err_count}, 16'h0000);
        @(negedge clk_3125) reset = 1'b0;

        // single write, loopback
        snap();
        base = got_q.size();
        @(negedge clk_3125);
        wr_en = 1'b1; wr_data = 8'hA5;
        @(posedge clk_3125);
        #1 wr_en = 1'b0;
        check("line_before_k1", tx_line, 1'b1);
        @(posedge clk_3125);
        #1;
        check("line_low_k1", tx_line, 1'b0);
        check("tx_busy", tx_busy, 1'b1);
        repeat (2) @(posedge clk_3125);
        for (int b = 0; b < 14; b++) begin
            #1 cap[b] = tx_line;
            repeat (CPB) @(posedge clk_3125);
        end
        check("tx_frame_bits", cap, {1'b1, 4'h0, 8'hA5, 1'b0});
        wait_rx(base + 1, 100);
        repeat (10) @(posedge clk_3125);
        #1;
        check("single_msg", rx_msg, 8'hA5);
        check("single_valid_cnt", n_valid - s_valid, 1);
        check("single_err_pulses", (n_replay - s_replay) + (n_gap - s_gap) + (n_ferr - s_ferr), 0);

        // FIFO overflow
        do_reset();
        snap();
        base = got_q.size();
        write_raw(8'h01);
        repeat (2) @(posedge clk_3125);
        write_raw(8'h02);
        write_raw(8'h03);
        write_raw(8'h04);
        check("full_at_3", full, 1'b0);
        write_raw(8'h05);
        check("full_at_4", full, 1'b1);
        write_raw(8'h06);
        check("full_after_drop", full, 1'b1);
        wait_rx(base + 5, 500);
        repeat (150) @(posedge clk_3125);
        #1;
        check("ovf_count", got_q.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < got_q.size())
                check("ovf_data", got_q[base + i], 32'(i + 1));
        check("ovf_err_count", err_count, 8'd0);
        check("ovf_err_pulses", (n_replay - s_replay) + (n_gap - s_gap) + (n_ferr - s_ferr), 0);
        check("ovf_idle", {full, tx_busy, tx_line}, 3'b001);

        // 17 frames: tx sequence wraps 15 -> 0
        do_reset();
        snap();
        base = got_q.size();
        for (int i = 0; i < 17; i++)
            write_wait(8'(i));
        wait_rx(base + 17, 1500);
        repeat (20) @(posedge clk_3125);
        check("wrap_count", got_q.size() - base, 17);
        for (int i = 0; i < 17; i++)
            if (base + i < got_q.size())
                check("wrap_data", got_q[base + i], 32'(i));
        check("wrap_err_pulses", (n_replay - s_replay) + (n_gap - s_gap) + (n_ferr - s_ferr), 0);

        // injected frames: replay, gap, boundary, framing
        loopback = 1'b0;
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].rst) do_reset();
            snap();
            inject(vecs[v].seq, vecs[v].data, vecs[v].stop);
            #1;
            check("vec_flags", {n_valid != s_valid, n_gap != s_gap, n_replay != s_replay, n_ferr != s_ferr}, vecs[v].flags);
            check("vec_one_pulse", (n_valid - s_valid) + (n_replay - s_replay) + (n_ferr - s_ferr), 1);
            check("vec_msg", rx_msg, vecs[v].msg);
            check("vec_err", err_count, vecs[v].err);
        end

        // err_count saturation: 255 more replays on top of one
        for (int i = 0; i < 254; i++)
            inject(4'd2, 8'hBB, 1'b1);
        #1 check("err_254", err_count, 8'd255);
        inject(4'd2, 8'hBB, 1'b1);
        #1 check("err_sat", err_count, 8'd255);
        check("sat_msg_kept", rx_msg, 8'h99);

        // reset in the middle of a loopback frame
        loopback = 1'b1;
        do_reset();
        write_raw(8'hC3);
        repeat (CPB + 10) @(posedge clk_3125);
        #3 reset = 1'b1;
        #1;
        check("midrst_line", tx_line, 1'b1);
        check("midrst_outs", {full, tx_busy, rx_valid, replay_error, seq_gap, frame_error, rx_msg, err_count}, 22'd0);
        repeat (2) @(posedge clk_3125);
        @(negedge clk_3125) reset = 1'b0;
        snap();
        repeat (100) @(posedge clk_3125);
        #1;
        check("midrst_no_pulse", (n_valid - s_valid) + (n_replay - s_replay) + (n_ferr - s_ferr), 0);
        check("midrst_idle", {tx_line, tx_busy}, 2'b10);

        check("exclusive_pulses", n_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
